// File: rtl/rv32_alu_if.sv
// Execute-stage ALU request/response bundle: operands, function fields, start pulse, result.
interface rv32_alu_if;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        is_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        ready;
  logic [31:0] out;
  logic        done;

  modport master (
    output in1, in2, is_imm, funct3, funct7, ready,
    input  out, done
  );

  modport slave (
    input  in1, in2, is_imm, funct3, funct7, ready,
    output out, done
  );
endinterface

// File: rtl/rv32_alu.sv
// RV32I/M integer ALU: single-cycle base ops, two-cycle multiply,
// 34-cycle radix-2 restoring divide, start-pulse/done handshake.
module rv32_alu #(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  rv32_alu_if.slave   bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              done_q, done_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              mul_hi_q, mul_hi_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              sel_rem_q, sel_rem_d;

  // Decode of the request presented on the bus this cycle
  logic              is_m;
  logic              alt;
  logic [CW-1:0]     shamt;
  logic [XLEN-1:0]   base_res;
  logic              mul_a_sgn, mul_b_sgn;
  logic [PW-1:0]     mul_a, mul_b, mul_prod;
  logic              div_sgn, div_rem, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b;

  // Divider step: shift in next dividend bit, subtract divisor if it fits
  logic [XLEN:0]     rem_t;
  logic              div_ge;

  assign is_m  = ENABLE_M && !bus.is_imm && (bus.funct7 == 7'b0000001);
  assign alt   = bus.funct7[5];
  assign shamt = bus.in2[CW-1:0];

  // Base RV32I result, computed straight from the live operands
  always_comb begin
    base_res = '0;
    unique case (bus.funct3)
      3'b000:  base_res = (!bus.is_imm && alt) ? bus.in1 - bus.in2 : bus.in1 + bus.in2;
      3'b001:  base_res = bus.in1 << shamt;
      3'b010:  base_res = {{(XLEN-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
      3'b011:  base_res = {{(XLEN-1){1'b0}}, (bus.in1 < bus.in2)};
      3'b100:  base_res = bus.in1 ^ bus.in2;
      3'b101:  base_res = alt ? $unsigned($signed(bus.in1) >>> shamt) : bus.in1 >> shamt;
      3'b110:  base_res = bus.in1 | bus.in2;
      default: base_res = bus.in1 & bus.in2;
    endcase
  end

  // Multiply operands sign- or zero-extended to 64 bits; low 64 bits of product are exact
  always_comb begin
    mul_a_sgn = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
    mul_b_sgn = (bus.funct3 == 3'b001);
    mul_a     = {{XLEN{mul_a_sgn & bus.in1[XLEN-1]}}, bus.in1};
    mul_b     = {{XLEN{mul_b_sgn & bus.in2[XLEN-1]}}, bus.in2};
    mul_prod  = PW'(mul_a * mul_b);
  end

  // Divide classification and operand magnitudes
  always_comb begin
    div_sgn  = !bus.funct3[0];
    div_rem  = bus.funct3[1];
    div_zero = (bus.in2 == '0);
    div_ovf  = div_sgn && (bus.in1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in2 == '1);
    abs_a    = (div_sgn && bus.in1[XLEN-1]) ? XLEN'(-bus.in1) : bus.in1;
    abs_b    = (div_sgn && bus.in2[XLEN-1]) ? XLEN'(-bus.in2) : bus.in2;
  end

  assign rem_t  = {rem_q, quo_q[XLEN-1]};
  assign div_ge = (rem_t >= {1'b0, dvs_q});

  // Next-state and next-output logic; a ready pulse always wins and restarts
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    done_d    = done_q;
    prod_d    = prod_q;
    mul_hi_d  = mul_hi_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;

    if (bus.ready) begin
      done_d  = 1'b0;
      state_d = ST_IDLE;
      if (!is_m) begin
        out_d  = base_res;
        done_d = 1'b1;
      end else if (!bus.funct3[2]) begin
        prod_d   = mul_prod;
        mul_hi_d = (bus.funct3 != 3'b000);
        state_d  = ST_MUL;
      end else if (div_zero) begin
        out_d  = div_rem ? bus.in1 : '1;
        done_d = 1'b1;
      end else if (div_ovf) begin
        out_d  = div_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        done_d = 1'b1;
      end else begin
        quo_d     = abs_a;
        rem_d     = '0;
        dvs_d     = abs_b;
        cnt_d     = '0;
        neg_quo_d = div_sgn && (bus.in1[XLEN-1] ^ bus.in2[XLEN-1]);
        neg_rem_d = div_sgn && bus.in1[XLEN-1];
        sel_rem_d = div_rem;
        state_d   = ST_DIV;
      end
    end else begin
      unique case (state_q)
        ST_MUL: begin
          out_d   = mul_hi_q ? prod_q[PW-1:XLEN] : prod_q[XLEN-1:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_DIV: begin
          rem_d = div_ge ? XLEN'(rem_t - {1'b0, dvs_q}) : rem_t[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], div_ge};
          cnt_d = CW'(cnt_q + CW'(1));
          if (cnt_q == '1) state_d = ST_FIX;
        end
        ST_FIX: begin
          if (sel_rem_q) out_d = neg_rem_q ? XLEN'(-rem_q) : rem_q;
          else           out_d = neg_quo_q ? XLEN'(-quo_q) : quo_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      out_q     <= '0;
      done_q    <= 1'b0;
      prod_q    <= '0;
      mul_hi_q  <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      done_q    <= done_d;
      prod_q    <= prod_d;
      mul_hi_q  <= mul_hi_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
    end
  end

  // done is masked by a new start so a stale result is never reported
  assign bus.out  = out_q;
  assign bus.done = done_q & ~bus.ready;

endmodule

// File: tb/tb_rv32_alu.sv
// Scoreboard bench for rv32_alu: expected result and latency queued at issue, compared at done.
module tb_rv32_alu;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;
  localparam int         MAX_LAT = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  rv32_alu_if bus_if ();

  rv32_alu #(.ENABLE_M(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic [31:0] last_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One-cycle start pulse; inputs are scrambled afterwards to prove they are sampled only at ready
  task automatic send(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus_if.funct3 = f3;
    bus_if.funct7 = f7;
    bus_if.is_imm = imm;
    bus_if.in1    = a;
    bus_if.in2    = b;
    bus_if.ready  = 1'b1;
    #1;
    check_eq("done_low_on_ready", {31'b0, bus_if.done}, 32'd0);
    @(negedge clk);
    bus_if.ready  = 1'b0;
    bus_if.in1    = $urandom;
    bus_if.in2    = $urandom;
    bus_if.funct3 = 3'($urandom);
    bus_if.funct7 = 7'($urandom);
    bus_if.is_imm = 1'($urandom);
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare result and latency
  task automatic collect();
    exp_t e;
    int   lat;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e   = sb_q.pop_front();
    lat = 1;
    #1;
    while (!bus_if.done && lat < MAX_LAT) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check_eq({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
    check_eq(e.tag, bus_if.out, e.val);
    last_exp = e.val;
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                     input logic imm, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    sb_q.push_back('{tag, exp, lat});
    send(f3, f7, imm, a, b);
    collect();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int drops;
    bus_if.in1    = '0;
    bus_if.in2    = '0;
    bus_if.is_imm = 1'b0;
    bus_if.funct3 = '0;
    bus_if.funct7 = '0;
    bus_if.ready  = 1'b0;
    last_exp      = '0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_out",  bus_if.out, 32'd0);
    check_eq("reset_done", {31'b0, bus_if.done}, 32'd0);
    rst = 1'b1;

    // Base ops
    run("add",    3'b000, F7_BASE, 1'b0, 32'd5,          32'd7,          32'd12,         1);
    run("sub",    3'b000, F7_ALT,  1'b0, 32'd3,          32'd5,          32'hFFFF_FFFE,  1);
    run("addi_f7",3'b000, F7_ALT,  1'b1, 32'd10,         32'd3,          32'd13,         1);
    run("sra",    3'b101, F7_ALT,  1'b0, 32'h8000_0000,  32'd4,          32'hF800_0000,  1);
    run("srai",   3'b101, F7_ALT,  1'b1, 32'h8000_0000,  32'd4,          32'hF800_0000,  1);
    run("srl",    3'b101, F7_BASE, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000,  1);
    run("slt",    3'b010, F7_BASE, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd1,          1);
    run("sltu",   3'b011, F7_BASE, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1);
    run("sll_msk",3'b001, F7_BASE, 1'b0, 32'd1,          32'd33,         32'd2,          1);
    run("xor",    3'b100, F7_BASE, 1'b0, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'hFF00_EDCB,  1);
    run("or",     3'b110, F7_BASE, 1'b0, 32'hF000_000F,  32'h0000_0FF0,  32'hF000_0FFF,  1);
    run("and",    3'b111, F7_BASE, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1);

    // Result held after done even though inputs keep changing
    repeat (3) @(negedge clk);
    #1;
    check_eq("hold_out",  bus_if.out, last_exp);
    check_eq("hold_done", {31'b0, bus_if.done}, 32'd1);

    // Multiply
    run("mulh",   3'b001, F7_M, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run("mulhu",  3'b011, F7_M, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run("mul",    3'b000, F7_M, 1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run("mulhsu", 3'b010, F7_M, 1'b0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2);

    // Divide
    run("div_neg",  3'b100, F7_M, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run("rem_neg",  3'b110, F7_M, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run("div_negd", 3'b100, F7_M, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run("rem_negd", 3'b110, F7_M, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'd1,         34);
    run("divu",     3'b101, F7_M, 1'b0, 32'd100,       32'd7,         32'd14,        34);
    run("remu",     3'b111, F7_M, 1'b0, 32'd100,       32'd7,         32'd2,         34);
    run("div_z",    3'b100, F7_M, 1'b0, 32'd1234,      32'd0,         32'hFFFF_FFFF, 1);
    run("rem_z",    3'b110, F7_M, 1'b0, 32'd1234,      32'd0,         32'd1234,      1);
    run("divu_z",   3'b101, F7_M, 1'b0, 32'd99,        32'd0,         32'hFFFF_FFFF, 1);
    run("div_ovf",  3'b100, F7_M, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",  3'b110, F7_M, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Reset in the middle of a divide clears out and done at once
    send(3'b101, F7_M, 1'b0, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_out",  bus_if.out, 32'd0);
    check_eq("rst_mid_done", {31'b0, bus_if.done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run("add_post_rst", 3'b000, F7_BASE, 1'b0, 32'd5, 32'd7, 32'd12, 1);

    // Restart: a new op aborts a divide in progress
    send(3'b100, F7_M, 1'b0, 32'd5000, 32'd7);
    repeat (8) @(negedge clk);
    run("add_restart", 3'b000, F7_BASE, 1'b0, 32'd1, 32'd1, 32'd2, 1);
    drops = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      #1;
      if (!bus_if.done || bus_if.out !== 32'd2) drops++;
    end
    check_eq("no_stale_div_done", 32'(drops), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv32_alu.md
Name: rv32_alu

Overview:
- Integer ALU for the pipelined RV32 core's execute stage.
- Computes all RV32I OP/OP-IMM results and, optionally, RV32M multiply/divide results.
- Uses a start-pulse/done handshake so multi-cycle operations can stall the pipeline.
- Operands and function fields come straight from the EX-stage registers and must stay stable until done.

Parameters:
ENABLE_M, 1, when 1 decode funct7=0000001 (register form) as RV32M; when 0 such encodings execute as the base op with funct7[5]=0.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-low.
in1  input  32  operand 1 (rs1).
in2  input  32  operand 2 (rs2 or sign-extended I-immediate).
is_imm  input  1  1 = OP-IMM encoding, 0 = OP (register) encoding.
funct3  input  3  instruction funct3.
funct7  input  7  instruction funct7 (imm[11:5] for OP-IMM).
ready  input  1  one-cycle start pulse; operands valid this cycle.
out  output  32  result, valid while done=1.
done  output  1  result valid / ALU idle.

Behaviour:
- Reset (rst=0, async): out=0, done=0, any operation in flight aborted, divider state cleared.
- done output = done_reg AND NOT ready, so done is low in any cycle where ready=1 (never reports a stale result on a new start).
- On a clk edge with ready=1: latch operands and function, clear done_reg, start the operation. A ready pulse while busy aborts the current op and restarts.
- Base ops (funct3):
  - 000: ADD; SUB only when is_imm=0 and funct7[5]=1.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1 (applies to both OP and OP-IMM).
  - 110: OR.
  - 111: AND.
- Base op arithmetic/width rules:
  - Shift amount = in2[4:0].
  - Compare results are 0 or 1, zero-extended.
  - All arithmetic wraps modulo 2^32.
  - When is_imm=1, funct7 is ignored except bit 5 for SRAI.
- Base ops: 1-cycle latency. out and done_reg are registered on the edge where ready is sampled, so done=1 on the following cycle.
- M ops: selected when ENABLE_M=1, is_imm=0, funct7=0000001.
  - 000 MUL: low 32 bits.
  - 001 MULH: high 32 bits, signed×signed.
  - 010 MULHSU: high 32 bits, signed×unsigned.
  - 011 MULHU: high 32 bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Multiply latency: 2 cycles. Registered 64-bit product, then select; done rises 2 cycles after ready.
- Divide latency:
  - Radix-2 restoring divider, 32 iterations on magnitudes, plus one sign-fix cycle.
  - done rises exactly 34 cycles after the ready cycle.
  - Signs: quotient negated if operand signs differ (signed ops); remainder takes the dividend's sign.
- Divide special cases, fixed 1-cycle latency:
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = in1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- After done: out and done stay held until the next ready or reset, even if inputs change.
- Inputs are sampled only at ready; later input changes do not affect an in-flight op.

Test Plan:
- Reset: rst low mid-divide → out=0, done=0 immediately. Release rst, pulse ready with ADD 5+7 → done=1 next cycle, out=12.
- SUB/SRA/SRAI/SLT: is_imm=0 funct7=0100000 funct3=000, in1=3, in2=5 → 0xFFFFFFFE. SRA 0x80000000>>4 → 0xF8000000. is_imm=1 funct3=101 funct7=0100000 in2=4 → same. SLT -1<1 → 1; SLTU → 0.
- Shift masking: SLL in1=1, in2=33 → 2. Also check done=0 during the ready cycle while the previous done was 1.
- Multiply: MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MUL 7×-3 → 0xFFFFFFEB. done exactly 2 cycles after ready.
- Divide: DIV -7/2 → -3; REM -7/2 → -1; DIVU 100/7 → 14, done at cycle 34. DIV x/0 → 0xFFFFFFFF; REM x/0 → x. DIV 0x80000000/-1 → 0x80000000.
- Restart: ready pulse at cycle 10 of a DIV with an ADD 1+1 → done next cycle, out=2. No later done from the aborted divide.
